// File: rtl/forney_pkg.sv
// Shared types for the Forney-stage lane collector.
//   LOC_W / SYM_W : error location and GF(2^10) magnitude widths
//   lane_beat_t   : one buffered Forney beat {loc, mag, last}
//   state_t       : collector FSM state
package forney_pkg;

   localparam int LOC_W = 10;
   localparam int SYM_W = 10;

   typedef struct packed {
      logic [LOC_W-1:0] loc;
      logic [SYM_W-1:0] mag;
      logic             last;
   } lane_beat_t;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO for Forney beats. No fall-through: a write into
// an empty FIFO becomes visible at the head on the following cycle.
//   clk_i, rst_i : clock, async active-high reset (empties the FIFO)
//   wr_en_i      : push wr_data_i (caller guarantees !full_o)
//   rd_en_i      : pop the head (caller guarantees !empty_o)
//   rd_data_o    : current head entry
//   full_o       : DEPTH entries stored (registered-state only)
//   empty_o      : no entries stored
module lane_fifo
   import forney_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_en_i,
   input  lane_beat_t wr_data_i,
   input  logic       rd_en_i,
   output lane_beat_t rd_data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);

   lane_beat_t     mem_q [DEPTH];
   lane_beat_t     mem_d [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_i) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data_i;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_en_i) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/forney_lane_collector.sv
// Collects per-lane Forney error lists and forwards one complete list at a
// time to the shared correction stage. Lanes are arbitrated round-robin at
// codeword granularity; a granted lane stays locked until its last beat is
// loaded into the output register.
//
//   state | meaning
//   IDLE  | no lane locked; arbitrate among non-empty lane FIFOs
//   LOCK  | lane lock_q owns the output until its last beat is loaded
//
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   in_valid/in_ready     : per-lane beat handshake (in_ready = FIFO not full)
//   in_loc/in_mag/in_last : per-lane beat fields, lane k at [k*W +: W]
//   out_valid/out_ready   : output handshake
//   out_lane              : source lane of the current beat
//   out_loc/out_mag       : error location / magnitude
//   out_last              : final beat of the codeword list
//   out_cnt               : beats of the list so far, including this one
module forney_lane_collector #(
   parameter int LANES      = 4,
   parameter int LOC_W      = forney_pkg::LOC_W,
   parameter int SYM_W      = forney_pkg::SYM_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [LANES-1:0]        in_valid,
   output logic [LANES-1:0]        in_ready,
   input  logic [LANES*LOC_W-1:0]  in_loc,
   input  logic [LANES*SYM_W-1:0]  in_mag,
   input  logic [LANES-1:0]        in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(LANES)-1:0] out_lane,
   output logic [LOC_W-1:0]        out_loc,
   output logic [SYM_W-1:0]        out_mag,
   output logic                    out_last,
   output logic [LOC_W-1:0]        out_cnt
);

   import forney_pkg::*;

   localparam int LW = $clog2(LANES);

   lane_beat_t        fifo_wdata [LANES];
   lane_beat_t        fifo_rdata [LANES];
   logic [LANES-1:0]  fifo_full;
   logic [LANES-1:0]  fifo_empty;
   logic [LANES-1:0]  fifo_pop;
   logic [LANES-1:0]  req;

   state_t            state_q, state_d;
   logic [LW-1:0]     lock_q, lock_d;
   logic [LANES-1:0]  mask_q, mask_d;
   logic [LOC_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [LW-1:0]     out_lane_q, out_lane_d;
   logic [LOC_W-1:0]  out_loc_q, out_loc_d;
   logic [SYM_W-1:0]  out_mag_q, out_mag_d;
   logic              out_last_q, out_last_d;
   logic [LOC_W-1:0]  out_cnt_q, out_cnt_d;

   logic [LANES-1:0]  masked_req;
   logic [LANES-1:0]  mask_above;
   logic [LW-1:0]     gnt_lane;
   logic              gnt_masked;
   logic [LOC_W-1:0]  cnt_inc;
   lane_beat_t        head_beat;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign fifo_wdata[k] = '{loc:  in_loc[k*LOC_W +: LOC_W],
                               mag:  in_mag[k*SYM_W +: SYM_W],
                               last: in_last[k]};

      lane_fifo #(
         .DEPTH     (FIFO_DEPTH)
      ) u_fifo (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .wr_en_i   (in_valid[k] && !fifo_full[k]),
         .wr_data_i (fifo_wdata[k]),
         .rd_en_i   (fifo_pop[k]),
         .rd_data_o (fifo_rdata[k]),
         .full_o    (fifo_full[k]),
         .empty_o   (fifo_empty[k])
      );
   end

   assign in_ready  = ~fifo_full;
   assign req       = ~fifo_empty;
   assign head_beat = fifo_rdata[lock_q];
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + LOC_W'(1);

   // Round-robin pick: lowest requester above the last grant, else lowest overall.
   always_comb begin
      masked_req = req & mask_q;
      gnt_masked = 1'b0;
      gnt_lane   = '0;
      for (int k = LANES-1; k >= 0; k--) begin
         if (masked_req[k]) begin
            gnt_lane   = LW'(k);
            gnt_masked = 1'b1;
         end
      end
      if (!gnt_masked) begin
         for (int k = LANES-1; k >= 0; k--) begin
            if (req[k]) begin
               gnt_lane = LW'(k);
            end
         end
      end
      mask_above = '0;
      for (int k = 0; k < LANES; k++) begin
         mask_above[k] = (k > int'(gnt_lane));
      end
      if (gnt_lane == LW'(LANES-1)) begin
         mask_above = '1;
      end
   end

   always_comb begin
      state_d     = state_q;
      lock_d      = lock_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_lane_d  = out_lane_q;
      out_loc_d   = out_loc_q;
      out_mag_d   = out_mag_q;
      out_last_d  = out_last_q;
      out_cnt_d   = out_cnt_q;
      fifo_pop    = '0;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = LOCK;
               lock_d  = gnt_lane;
               mask_d  = mask_above;
            end
         end
         LOCK: begin
            if ((!out_valid_q || out_ready) && !fifo_empty[lock_q]) begin
               fifo_pop[lock_q] = 1'b1;
               out_valid_d      = 1'b1;
               out_lane_d       = lock_q;
               out_loc_d        = head_beat.loc;
               out_mag_d        = head_beat.mag;
               out_last_d       = head_beat.last;
               out_cnt_d        = cnt_inc;
               cnt_d            = head_beat.last ? '0 : cnt_inc;
               if (head_beat.last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         lock_q      <= '0;
         mask_q      <= '1;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_lane_q  <= '0;
         out_loc_q   <= '0;
         out_mag_q   <= '0;
         out_last_q  <= 1'b0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         lock_q      <= lock_d;
         mask_q      <= mask_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_lane_q  <= out_lane_d;
         out_loc_q   <= out_loc_d;
         out_mag_q   <= out_mag_d;
         out_last_q  <= out_last_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_lane  = out_lane_q;
   assign out_loc   = out_loc_q;
   assign out_mag   = out_mag_q;
   assign out_last  = out_last_q;
   assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_forney_lane_collector.sv
// Directed bench for forney_lane_collector (LANES=4, depth-2 FIFOs).
module tb_forney_lane_collector;

   logic         clk_i;
   logic         rst_i;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [39:0]  in_loc;
   logic [39:0]  in_mag;
   logic [3:0]   in_last;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   out_lane;
   logic [9:0]   out_loc;
   logic [9:0]   out_mag;
   logic         out_last;
   logic [9:0]   out_cnt;

   logic         d_valid [4];
   logic [9:0]   d_loc   [4];
   logic [9:0]   d_mag   [4];
   logic         d_last  [4];

   int n_assert;
   int n_fail;
   int cyc;

   typedef struct packed {
      int lane;
      int loc;
      int mag;
      int cnt;
      int cyc;
      bit last;
   } obs_t;
   obs_t obs[$];

   forney_lane_collector #(
      .LANES      (4),
      .LOC_W      (10),
      .SYM_W      (10),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_loc    (in_loc),
      .in_mag    (in_mag),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lane  (out_lane),
      .out_loc   (out_loc),
      .out_mag   (out_mag),
      .out_last  (out_last),
      .out_cnt   (out_cnt)
   );

   for (genvar k = 0; k < 4; k++) begin : g_drv
      assign in_valid[k]         = d_valid[k];
      assign in_loc[k*10 +: 10]  = d_loc[k];
      assign in_mag[k*10 +: 10]  = d_mag[k];
      assign in_last[k]          = d_last[k];
   end

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Record every accepted output beat with the cycle it was presented.
   always @(negedge clk_i) begin
      if (!rst_i && out_valid && out_ready) begin
         obs.push_back('{lane: int'(out_lane), loc: int'(out_loc), mag: int'(out_mag),
                         cnt: int'(out_cnt), cyc: cyc, last: out_last});
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      for (int k = 0; k < 4; k++) begin
         d_valid[k] = 1'b0;
         d_loc[k]   = '0;
         d_mag[k]   = '0;
         d_last[k]  = 1'b0;
      end
      rst_i = 1'b1;
      repeat (2) tick();
      rst_i = 1'b0;
      obs.delete();
      tick();
   endtask

   // Present one beat on lane k and hold it until the FIFO takes it.
   task automatic send_beat(input int k, input int loc, input bit last);
      logic ok;
      ok         = 1'b0;
      d_loc[k]   = 10'(loc);
      d_mag[k]   = 10'(loc + 1);
      d_last[k]  = last;
      d_valid[k] = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk_i);
         ok = in_ready[k];
         tick();
         if (ok) break;
      end
      d_valid[k] = 1'b0;
      if (!ok) begin
         n_assert++;
         n_fail++;
         $display("FAIL send_timeout lane=%0d loc=%0d in_ready never rose", k, loc);
      end
   endtask

   task automatic wait_beats(input int n);
      for (int t = 0; t < 300 && obs.size() < n; t++) tick();
      repeat (4) tick();
      n_assert++;
      if (obs.size() !== n) begin
         n_fail++;
         $display("FAIL beat_count got=%0d want=%0d", obs.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_i     = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         d_valid[k] = 1'b0;
         d_loc[k]   = '0;
         d_mag[k]   = '0;
         d_last[k]  = 1'b0;
      end
      #12;
      n_assert++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_assert++;
      if (in_ready !== 4'hF) begin n_fail++; $display("FAIL reset_in_ready got=%h want=f", in_ready); end
      n_assert++;
      if ({out_lane, out_loc, out_mag, out_last, out_cnt} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_out_fields lane=%0d loc=%0d mag=%0d last=%b cnt=%0d want all 0",
                  out_lane, out_loc, out_mag, out_last, out_cnt);
      end
      tick();
      rst_i = 1'b0;
      obs.delete();
      tick();
   endtask

   task automatic test_single_lane();
      int start;
      int exp_loc  [3] = '{5, 17, 300};
      int exp_cnt  [3] = '{1, 2, 3};
      bit exp_last [3] = '{0, 0, 1};
      do_reset();
      out_ready = 1'b1;
      start = cyc;
      send_beat(2, 5, 1'b0);
      send_beat(2, 17, 1'b0);
      send_beat(2, 300, 1'b1);
      wait_beats(3);
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (i >= obs.size()) begin
            n_fail++; $display("FAIL single_beat%0d missing", i);
         end else if (obs[i].lane !== 2 || obs[i].loc !== exp_loc[i] || obs[i].mag !== exp_loc[i] + 1 ||
                      obs[i].cnt !== exp_cnt[i] || obs[i].last !== exp_last[i]) begin
            n_fail++;
            $display("FAIL single_beat%0d got lane=%0d loc=%0d mag=%0d cnt=%0d last=%b want lane=2 loc=%0d cnt=%0d last=%b",
                     i, obs[i].lane, obs[i].loc, obs[i].mag, obs[i].cnt, obs[i].last,
                     exp_loc[i], exp_cnt[i], exp_last[i]);
         end
      end
      n_assert++;
      if (obs.size() > 0 && obs[0].cyc - start !== 3) begin
         n_fail++; $display("FAIL single_latency got=%0d want=3", obs[0].cyc - start);
      end
   endtask

   task automatic test_all_lanes();
      int exp_lane [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int exp_loc  [10] = '{100, 101, 110, 111, 120, 121, 130, 131, 200, 201};
      do_reset();
      out_ready = 1'b0;
      fork
         begin send_beat(0, 100, 1'b0); send_beat(0, 101, 1'b1); end
         begin send_beat(1, 110, 1'b0); send_beat(1, 111, 1'b1); end
         begin send_beat(2, 120, 1'b0); send_beat(2, 121, 1'b1); end
         begin send_beat(3, 130, 1'b0); send_beat(3, 131, 1'b1); end
      join
      fork
         begin send_beat(0, 200, 1'b0); send_beat(0, 201, 1'b1); end
         begin repeat (3) tick(); out_ready = 1'b1; end
      join
      wait_beats(10);
      for (int i = 0; i < 10; i++) begin
         n_assert++;
         if (i >= obs.size()) begin
            n_fail++; $display("FAIL rr_beat%0d missing", i);
         end else if (obs[i].lane !== exp_lane[i] || obs[i].loc !== exp_loc[i] ||
                      obs[i].cnt !== (i % 2) + 1 || obs[i].last !== bit'(i % 2)) begin
            n_fail++;
            $display("FAIL rr_beat%0d got lane=%0d loc=%0d cnt=%0d last=%b want lane=%0d loc=%0d cnt=%0d",
                     i, obs[i].lane, obs[i].loc, obs[i].cnt, obs[i].last, exp_lane[i], exp_loc[i], (i % 2) + 1);
         end
      end
      for (int i = 1; i < 10 && i < obs.size(); i++) begin
         n_assert++;
         if (obs[i].cyc - obs[i-1].cyc !== ((i % 2 == 0) ? 2 : 1)) begin
            n_fail++;
            $display("FAIL rr_gap%0d got=%0d want=%0d", i, obs[i].cyc - obs[i-1].cyc, (i % 2 == 0) ? 2 : 1);
         end
      end
   endtask

   task automatic test_mask_wrap();
      int exp_lane [5] = '{0, 0, 3, 3, 0};
      int exp_loc  [5] = '{300, 301, 310, 311, 320};
      int other;
      do_reset();
      out_ready = 1'b1;
      fork
         begin send_beat(0, 300, 1'b0); send_beat(0, 301, 1'b1); send_beat(0, 320, 1'b1); end
         begin send_beat(3, 310, 1'b0); send_beat(3, 311, 1'b1); end
      join
      wait_beats(5);
      other = 0;
      for (int i = 0; i < 5; i++) begin
         n_assert++;
         if (i >= obs.size()) begin
            n_fail++; $display("FAIL mask_beat%0d missing", i);
         end else if (obs[i].lane !== exp_lane[i] || obs[i].loc !== exp_loc[i]) begin
            n_fail++;
            $display("FAIL mask_beat%0d got lane=%0d loc=%0d want lane=%0d loc=%0d",
                     i, obs[i].lane, obs[i].loc, exp_lane[i], exp_loc[i]);
         end
      end
      foreach (obs[i]) if (obs[i].lane == 1 || obs[i].lane == 2) other++;
      n_assert++;
      if (other !== 0) begin n_fail++; $display("FAIL mask_idle_lanes got=%0d grants want=0", other); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b1;
      send_beat(1, 40, 1'b0);
      send_beat(1, 41, 1'b0);
      repeat (2) tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 2) begin
            d_loc[1]   = 10'(42 + i);
            d_mag[1]   = 10'(43 + i);
            d_last[1]  = 1'b0;
            d_valid[1] = 1'b1;
         end else begin
            d_valid[1] = 1'b0;
         end
         @(negedge clk_i);
         n_assert++;
         if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_loc !== 10'd41 || out_mag !== 10'd42 ||
             out_cnt !== 10'd2 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold%0d got valid=%b lane=%0d loc=%0d mag=%0d cnt=%0d last=%b want 1/1/41/42/2/0",
                     i, out_valid, out_lane, out_loc, out_mag, out_cnt, out_last);
         end
         if (i >= 2) begin
            n_assert++;
            if (in_ready[1] !== 1'b0) begin
               n_fail++; $display("FAIL stall_in_ready%0d got=%b want=0", i, in_ready[1]);
            end
         end
         tick();
      end
      d_valid[1] = 1'b0;
      out_ready  = 1'b1;
      send_beat(1, 44, 1'b0);
      send_beat(1, 45, 1'b1);
      wait_beats(6);
      for (int i = 0; i < 6; i++) begin
         n_assert++;
         if (i >= obs.size()) begin
            n_fail++; $display("FAIL stall_beat%0d missing", i);
         end else if (obs[i].lane !== 1 || obs[i].loc !== 40 + i || obs[i].mag !== 41 + i ||
                      obs[i].cnt !== i + 1 || obs[i].last !== (i == 5)) begin
            n_fail++;
            $display("FAIL stall_beat%0d got lane=%0d loc=%0d cnt=%0d last=%b want lane=1 loc=%0d cnt=%0d",
                     i, obs[i].lane, obs[i].loc, obs[i].cnt, obs[i].last, 40 + i, i + 1);
         end
      end
   endtask

   task automatic test_lane_starve();
      int exp_lane [3] = '{1, 1, 0};
      int exp_loc  [3] = '{50, 51, 60};
      int exp_cnt  [3] = '{1, 2, 1};
      do_reset();
      out_ready = 1'b1;
      send_beat(1, 50, 1'b0);
      send_beat(0, 60, 1'b1);
      repeat (8) tick();
      n_assert++;
      if (obs.size() !== 1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL starve_hold got beats=%0d valid=%b want beats=1 valid=0", obs.size(), out_valid);
      end
      send_beat(1, 51, 1'b1);
      wait_beats(3);
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (i >= obs.size()) begin
            n_fail++; $display("FAIL starve_beat%0d missing", i);
         end else if (obs[i].lane !== exp_lane[i] || obs[i].loc !== exp_loc[i] || obs[i].cnt !== exp_cnt[i]) begin
            n_fail++;
            $display("FAIL starve_beat%0d got lane=%0d loc=%0d cnt=%0d want lane=%0d loc=%0d cnt=%0d",
                     i, obs[i].lane, obs[i].loc, obs[i].cnt, exp_lane[i], exp_loc[i], exp_cnt[i]);
         end
      end
   endtask

   task automatic test_reset_mid_list();
      int exp_lane [3] = '{0, 3, 3};
      int exp_loc  [3] = '{90, 80, 81};
      int exp_cnt  [3] = '{1, 1, 2};
      do_reset();
      out_ready = 1'b0;
      send_beat(2, 70, 1'b0);
      send_beat(2, 71, 1'b0);
      send_beat(2, 72, 1'b0);
      tick();
      rst_i = 1'b1;
      #1;
      n_assert++;
      if (out_valid !== 1'b0 || in_ready !== 4'hF || out_cnt !== 10'd0) begin
         n_fail++;
         $display("FAIL midreset_state got valid=%b in_ready=%h cnt=%0d want 0/f/0", out_valid, in_ready, out_cnt);
      end
      tick();
      rst_i = 1'b0;
      obs.delete();
      out_ready = 1'b1;
      fork
         send_beat(0, 90, 1'b1);
         begin send_beat(3, 80, 1'b0); send_beat(3, 81, 1'b1); end
      join
      wait_beats(3);
      for (int i = 0; i < 3; i++) begin
         n_assert++;
         if (i >= obs.size()) begin
            n_fail++; $display("FAIL midreset_beat%0d missing", i);
         end else if (obs[i].lane !== exp_lane[i] || obs[i].loc !== exp_loc[i] || obs[i].cnt !== exp_cnt[i]) begin
            n_fail++;
            $display("FAIL midreset_beat%0d got lane=%0d loc=%0d cnt=%0d want lane=%0d loc=%0d cnt=%0d",
                     i, obs[i].lane, obs[i].loc, obs[i].cnt, exp_lane[i], exp_loc[i], exp_cnt[i]);
         end
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      test_reset();
      test_single_lane();
      test_all_lanes();
      test_mask_wrap();
      test_backpressure();
      test_lane_starve();
      test_reset_mid_list();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/forney_lane_collector.md
Name: forney_lane_collector

Overview:
- Downstream consumer of the round-robin arbiter in the Forney stage of the RS(544,514) decoder.
- LANES parallel Forney lanes each emit (error location, error magnitude) beats; each codeword's error list ends with a last flag.
- This block buffers each lane, arbitrates round-robin at codeword granularity, and delivers one contiguous error list at a time to the shared correction stage over valid/ready.

Parameters:
LANES, 4, number of Forney lanes; legal values 4 or 8.
LOC_W, 10, error location width (symbol index 0..543).
SYM_W, 10, GF(2^10) error magnitude width.
FIFO_DEPTH, 2, per-lane buffer entries; power of 2, at least 2.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; asynchronous, active-high.
in_valid  in  LANES  per-lane beat valid.
in_ready  out  LANES  per-lane FIFO not full.
in_loc  in  LANES*LOC_W  per-lane location; lane k occupies bits [k*LOC_W +: LOC_W].
in_mag  in  LANES*SYM_W  per-lane magnitude.
in_last  in  LANES  last beat of the lane's codeword error list.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accept.
out_lane  out  $clog2(LANES)  source lane of the beat.
out_loc  out  LOC_W  location.
out_mag  out  SYM_W  magnitude.
out_last  out  1  end of codeword list.
out_cnt  out  LOC_W  beats in the list, including the current beat; valid with out_valid.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all FIFOs empty; in_ready all 1.
  - out_valid=0; out_lane, out_loc, out_mag, out_last, out_cnt = 0.
  - FSM in IDLE; priority mask all ones; beat counter = 0.
- Reset mid-list discards all buffered and in-flight beats. No partial list resumes.
- Per-lane FIFO:
  - write when in_valid[k] && in_ready[k].
  - in_ready[k] = !full[k], registered-state based, with no combinational path from out_ready.
  - Simultaneous read and write when full: write blocked (in_ready=0). When empty, the write appears at the head next cycle; no fall-through.
- Arbitration (IDLE state):
  - req[k] = FIFO k non-empty.
  - Grant the lowest-index req within the mask. If the masked set is empty, grant the lowest-index req.
  - When lane g is granted, the mask becomes the bits above g. If g = LANES-1, the mask becomes all ones.
  - The mask updates only when a grant is taken.
  - If no req, stay in IDLE.
- FSM:
  - IDLE -> LOCK(g) on a grant.
  - LOCK pops lane g only. Other lanes are never interleaved.
  - LOCK -> IDLE on the cycle the output register accepts a beat with last=1. Arbitration resumes in the same cycle the state returns to IDLE, so the earliest next grant is the following cycle.
  - A beat with last=1 as the only beat of a list (a zero-length list is impossible) is legal: IDLE -> LOCK -> IDLE.
- Output register (single stage):
  - loads when (!out_valid || out_ready) and the locked lane's FIFO is non-empty.
  - holds all out_* stable while out_valid && !out_ready.
  - Latency: an input beat into an empty FIFO of an idle collector reaches out_valid in 3 cycles (FIFO write, grant, output load).
  - Sustained throughput is 1 beat/cycle within a list; there is 1 bubble cycle between lists.
- out_cnt:
  - counter starts at 1 on the first beat of a list and increments per loaded beat.
  - resets to 0 after the last beat is loaded.
  - saturates at 2^LOC_W-1.
- An empty LOCK FIFO (lane stalled mid-list) leaves out_valid deasserted after drain. Lock is held indefinitely; no timeout.

Decomposition:
- Package forney_pkg: LOC_W and SYM_W constants, the lane beat struct {loc, mag, last}, and the FSM state enum {IDLE, LOCK}.
- Sub-module lane_fifo: per-lane synchronous FIFO with full/empty flags; instantiated LANES times.
- Arbitration mask and FSM live in the top module.

Test Plan:
- Single lane 2, list of 3 beats (loc 5, 17, 300; last on 300), out_ready=1 -> beats out in order, out_lane=2, out_cnt 1,2,3, out_last only on third; first out_valid 3 cycles after first in_valid.
- All 4 lanes, each with a 2-beat list present at once -> lists emitted lane order 0,1,2,3 then back to 0, never interleaved, 1 idle cycle between lists.
- Lanes 0 and 3 active, mask after lane 0 = 1110 -> next grant lane 3, then mask 1111 -> lane 0; lanes 1 and 2 never granted.
- out_ready held low 5 cycles mid-list -> out_* stable; lane FIFO fills, in_ready drops to 0 after 2 more writes; no beat lost or duplicated after release.
- Lane 1 locked, its FIFO runs empty mid-list while lane 0 has data -> no lane 0 beat output until lane 1 delivers last.
- rst_i asserted mid-list for 1 cycle -> out_valid=0 and in_ready all 1 immediately, mask all ones; a fresh lane 3 list then outputs with out_cnt starting at 1.
